// File: rtl/hello_pkg.sv
// Shared constants for the HEX0 "HELLO" display path and its receive-side
// decoder: active-low 7-segment patterns (bit6=g ... bit0=a), decoded
// character codes, and the word-tracking FSM state encodings.
package hello_pkg;

    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        CH_BLANK = 3'd0,
        CH_H     = 3'd1,
        CH_E     = 3'd2,
        CH_L     = 3'd3,
        CH_O     = 3'd4,
        CH_UNK   = 3'd7
    } char_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H    = 3'd1,
        S_HE   = 3'd2,
        S_HEL  = 3'd3,
        S_HELL = 3'd4
    } state_t;

    // Character that advances the word from a given state.
    function automatic char_t expected_char(input state_t s);
        case (s)
            S_IDLE:  return CH_H;
            S_H:     return CH_E;
            S_HE:    return CH_L;
            S_HEL:   return CH_L;
            S_HELL:  return CH_O;
            default: return CH_H;
        endcase
    endfunction

    // Successor state on an expected character (S_HELL wraps to idle).
    function automatic state_t advance(input state_t s);
        case (s)
            S_IDLE:  return S_H;
            S_H:     return S_HE;
            S_HE:    return S_HEL;
            S_HEL:   return S_HELL;
            default: return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hello_seg_decoder_seg7_char_decode.sv
// Combinational 7-segment pattern to character-code decoder.
// Ports:
//   seg_in - active-low segment pattern, bit6=g ... bit0=a
//   code   - 0=blank, 1=H, 2=E, 3=L, 4=O, 7=unknown pattern
module seg7_char_decode
    import hello_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [2:0] code
);

    always_comb begin
        code = CH_UNK;
        case (seg_in)
            SEG_H:     code = CH_H;
            SEG_E:     code = CH_E;
            SEG_L:     code = CH_L;
            SEG_O:     code = CH_O;
            SEG_BLANK: code = CH_BLANK;
            default:   code = CH_UNK;
        endcase
    end

endmodule

// File: rtl/hello_seg_decoder.sv
// Receive-side decoder for a strobed stream of 7-segment patterns. Each
// strobe is decoded to a character and checked against the H-E-L-L-O word
// order; completed words, order errors and mid-word timeouts are reported
// as one-cycle pulses. All outputs are registered (1 cycle after strobe).
// Ports:
//   CLOCK_50   - system clock, rising edge
//   SW[0]      - synchronous active-high reset
//   seg_in     - active-low segment pattern, sampled when seg_valid=1
//   seg_valid  - one-cycle strobe per character
//   char_code  - last decoded character code
//   char_valid - pulse: char_code updated
//   word_done  - pulse: full HELLO received
//   seq_err    - pulse: order error, unknown pattern or timeout
//   word_count - completed words, wraps silently
//   state      - current FSM state for debug LEDs
module hello_seg_decoder
    import hello_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000000,
    parameter int CNT_W       = 8
)(
    input  logic             CLOCK_50,
    input  logic [0:0]       SW,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    output logic [2:0]       char_code,
    output logic             char_valid,
    output logic             word_done,
    output logic             seq_err,
    output logic [CNT_W-1:0] word_count,
    output logic [2:0]       state
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [2:0]         dec_code;
    char_t              code_p0;
    state_t             state_q;
    logic [TIMER_W-1:0] timer;

    seg7_char_decode u_decode (
        .seg_in (seg_in),
        .code   (dec_code)
    );

    assign code_p0 = char_t'(dec_code);
    assign state   = state_q;

    // Stage boundary: decoded strobe -> registered outputs and FSM state
    always_ff @(posedge CLOCK_50) begin
        if (SW[0]) begin
            state_q    <= S_IDLE;
            char_code  <= CH_BLANK;
            char_valid <= 1'b0;
            word_done  <= 1'b0;
            seq_err    <= 1'b0;
            word_count <= '0;
            timer      <= '0;
        end else begin
            char_valid <= seg_valid;
            word_done  <= 1'b0;
            seq_err    <= 1'b0;
            if (seg_valid) begin
                char_code <= dec_code;
            end

            case (state_q)
                S_IDLE, S_H, S_HE, S_HEL, S_HELL: begin
                    if (seg_valid) begin
                        // Blank strobes are transparent: state and timer hold.
                        if (code_p0 != CH_BLANK) begin
                            timer <= '0;
                            if (code_p0 == expected_char(state_q)) begin
                                if (state_q == S_HELL) begin
                                    word_done  <= 1'b1;
                                    word_count <= word_count + CNT_W'(1);
                                end
                                state_q <= advance(state_q);
                            end else if (code_p0 == CH_H) begin
                                // An out-of-place H starts a fresh word.
                                seq_err <= 1'b1;
                                state_q <= S_H;
                            end else begin
                                seq_err <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end else if (state_q == S_IDLE) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        // A strobe on this same cycle takes the branch above
                        // instead, so it is never flagged as a timeout.
                        seq_err <= 1'b1;
                        state_q <= S_IDLE;
                        timer   <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hello_seg_decoder.sv
module tb_hello_seg_decoder;

    logic       clk;
    logic [0:0] sw;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic [2:0] char_code;
    logic       char_valid;
    logic       word_done;
    logic       seq_err;
    logic [1:0] word_count;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] P_H   = 7'b0001001;
    localparam logic [6:0] P_E   = 7'b0000110;
    localparam logic [6:0] P_L   = 7'b1000111;
    localparam logic [6:0] P_O   = 7'b1000000;
    localparam logic [6:0] P_BLK = 7'b1111111;
    localparam logic [6:0] P_BAD = 7'b0101010;

    hello_seg_decoder #(
        .TIMEOUT_CYC (10),
        .CNT_W       (2)
    ) dut (
        .CLOCK_50   (clk),
        .SW         (sw),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .char_code  (char_code),
        .char_valid (char_valid),
        .word_done  (word_done),
        .seq_err    (seq_err),
        .word_count (word_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, then settle 1 ns for sampling.
    task automatic step(input logic v, input logic [6:0] s);
        seg_valid = v;
        seg_in    = s;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_in    = P_BLK;
    endtask

    task automatic do_reset();
        sw = 1'b1;
        step(1'b0, P_BLK);
        sw = 1'b0;
    endtask

    task automatic send_word();
        step(1'b1, P_H);
        step(1'b1, P_E);
        step(1'b1, P_L);
        step(1'b1, P_L);
        step(1'b1, P_O);
    endtask

    initial begin
        sw        = 1'b1;
        seg_in    = P_BLK;
        seg_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check("rst_state", state, 0);
        check("rst_code", char_code, 0);
        check("rst_cv", char_valid, 0);
        check("rst_wd", word_done, 0);
        check("rst_err", seq_err, 0);
        check("rst_wc", word_count, 0);

        // Clean HELLO, one strobe per cycle
        step(1'b1, P_H);
        check("w1_h_code", char_code, 1); check("w1_h_cv", char_valid, 1);
        check("w1_h_st", state, 1);
        step(1'b1, P_E);
        check("w1_e_code", char_code, 2); check("w1_e_st", state, 2);
        step(1'b1, P_L);
        check("w1_l_code", char_code, 3); check("w1_l_st", state, 3);
        step(1'b1, P_L);
        check("w1_l2_code", char_code, 3); check("w1_l2_st", state, 4);
        check("w1_l2_wd", word_done, 0);
        step(1'b1, P_O);
        check("w1_o_code", char_code, 4); check("w1_o_wd", word_done, 1);
        check("w1_o_wc", word_count, 1); check("w1_o_st", state, 0);
        check("w1_o_err", seq_err, 0);
        step(1'b0, P_BLK);
        check("w1_idle_wd", word_done, 0); check("w1_idle_cv", char_valid, 0);

        // Repeated E in S_HE, then H restarts
        do_reset();
        step(1'b1, P_H);
        step(1'b1, P_E);
        step(1'b1, P_E);
        check("ee_err", seq_err, 1); check("ee_st", state, 0);
        step(1'b1, P_H);
        check("ee_h_err", seq_err, 0); check("ee_h_st", state, 1);

        // H in S_HEL resyncs to S_H, then word completes
        do_reset();
        step(1'b1, P_H);
        step(1'b1, P_E);
        step(1'b1, P_L);
        step(1'b1, P_H);
        check("rs_err", seq_err, 1); check("rs_st", state, 1);
        step(1'b1, P_E);
        step(1'b1, P_L);
        step(1'b1, P_L);
        step(1'b1, P_O);
        check("rs_wd", word_done, 1); check("rs_wc", word_count, 1);

        // Timeout: seq_err exactly 10 cycles after H takes effect
        do_reset();
        step(1'b1, P_H);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, P_BLK);
            check($sformatf("to_wait%0d_err", i), seq_err, 0);
            check($sformatf("to_wait%0d_st", i), state, 1);
        end
        step(1'b0, P_BLK);
        check("to_err", seq_err, 1); check("to_st", state, 0);
        step(1'b0, P_BLK);
        check("to_after_err", seq_err, 0); check("to_after_st", state, 0);

        // Strobe on the expiry cycle wins
        do_reset();
        step(1'b1, P_H);
        for (int i = 1; i <= 9; i++) step(1'b0, P_BLK);
        step(1'b1, P_E);
        check("tx_err", seq_err, 0); check("tx_st", state, 2);
        check("tx_code", char_code, 2); check("tx_cv", char_valid, 1);

        // Unknown pattern, then blank mid-word
        do_reset();
        step(1'b1, P_BAD);
        check("unk_code", char_code, 7); check("unk_err", seq_err, 1);
        check("unk_st", state, 0);
        step(1'b1, P_H);
        step(1'b1, P_BLK);
        check("blk_code", char_code, 0); check("blk_cv", char_valid, 1);
        check("blk_err", seq_err, 0); check("blk_st", state, 1);
        step(1'b1, P_E);
        check("blk_e_st", state, 2);

        // 2-bit word counter wraps 3 -> 0
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            send_word();
            check($sformatf("wrap_w%0d_wc", w), word_count, w % 4);
            check($sformatf("wrap_w%0d_wd", w), word_done, 1);
        end

        // Reset mid-word with a strobe present
        step(1'b1, P_H);
        step(1'b1, P_E);
        sw = 1'b1;
        step(1'b1, P_L);
        sw = 1'b0;
        check("mr_st", state, 0); check("mr_wc", word_count, 0);
        check("mr_cv", char_valid, 0); check("mr_wd", word_done, 0);
        check("mr_err", seq_err, 0); check("mr_code", char_code, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
